// File: rtl/logic_sweep_tester.sv
// Stimulus-and-capture sweep for a three-input gate network: drives {A,B,C}=0..7, captures P/Q per vector.
// Optional golden comparison enabled by defining LOGIC_SWEEP_GOLDEN_CHECK_EN.
module logic_sweep_tester #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        P_in,
  input  logic        Q_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  mismatch,
  output logic        pass,
  output logic [1:0]  o_dbg_state
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse with result/pass valid alongside it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_abc;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   r_result;

`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
  logic [7:0] r_mismatch;
  logic       r_valid;
  logic       w_gold_p;
  logic       w_gold_q;
  logic       w_miss;

  assign w_gold_p = ~r_idx[1] & (r_idx[2] | r_idx[0]);
  assign w_gold_q = ~r_idx[2] & (~r_idx[1] | ~r_idx[0]);
  assign w_miss   = ({P_in, Q_in} != {w_gold_p, w_gold_q});
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= '0;
      r_abc      <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 16'h0000;
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
      r_mismatch <= 8'h00;
      r_valid    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= S_HOLD;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_abc      <= 3'd0;
            r_busy     <= 1'b1;
            r_result   <= 16'h0000;
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
            r_mismatch <= 8'h00;
            r_valid    <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          if (r_cnt == CNT_LAST) begin
            // Capture edge: P/Q have settled for the full hold window.
            r_result[{r_idx, 1'b0} +: 2] <= {P_in, Q_in};
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
            r_mismatch[r_idx] <= w_miss;
`endif
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_DONE;
              r_abc   <= 3'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
              r_valid <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
              r_abc <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {A, B, C}   = r_abc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign o_dbg_state = r_state;

`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
  assign mismatch = r_mismatch;
  assign pass     = r_valid & ~r_busy & (r_mismatch == 8'h00);
`else
  assign mismatch = 8'h00;
  assign pass     = 1'b0;
`endif

endmodule

// File: tb/tb_logic_sweep_tester.sv
// Directed bench for logic_sweep_tester: one instance at HOLD_CYCLES=4, one at HOLD_CYCLES=1,
// each driving a behavioural gate network with an optional P stuck-at-0 fault.
module tb_logic_sweep_tester;

  logic clk;
  logic reset;

  logic start4, stuck4, p4, q4, a4, b4, c4, busy4, done4, pass4;
  logic [15:0] result4;
  logic [7:0]  mismatch4;
  logic [1:0]  st4;

  logic start1, stuck1, p1, q1, a1, b1, c1, busy1, done1, pass1;
  logic [15:0] result1;
  logic [7:0]  mismatch1;
  logic [1:0]  st1;

  int n_vec;
  int n_miss;
  logic [15:0] exp_q[$];

  // Gate network under test
  assign p4 = stuck4 ? 1'b0 : (~b4 & (a4 | c4));
  assign q4 = ~a4 & (~b4 | ~c4);
  assign p1 = stuck1 ? 1'b0 : (~b1 & (a1 | c1));
  assign q1 = ~a1 & (~b1 | ~c1);

  logic_sweep_tester #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .P_in(p4), .Q_in(q4),
    .A(a4), .B(b4), .C(c4), .busy(busy4), .done(done4),
    .result(result4), .mismatch(mismatch4), .pass(pass4), .o_dbg_state(st4)
  );

  logic_sweep_tester #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .P_in(p1), .Q_in(q1),
    .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
    .result(result1), .mismatch(mismatch1), .pass(pass1), .o_dbg_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected capture word built from the published golden tables (P=8'h32, Q=8'h07).
  function automatic logic [15:0] exp_result(input logic stuck);
    logic [7:0]  gp;
    logic [7:0]  gq;
    logic [15:0] r;
    gp = 8'h32;
    gq = 8'h07;
    r  = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = stuck ? 1'b0 : gp[i];
      r[2*i]   = gq[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_mismatch(input logic stuck);
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
    return stuck ? 8'h32 : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic exp_pass(input logic stuck);
`ifdef LOGIC_SWEEP_GOLDEN_CHECK_EN
    return ~stuck;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_abc4"}, {13'd0, a4, b4, c4}, 16'd0);
    check({tag, "_busy4"}, {15'd0, busy4}, 16'd0);
    check({tag, "_done4"}, {15'd0, done4}, 16'd0);
    check({tag, "_result4"}, result4, 16'h0000);
    check({tag, "_mismatch4"}, {8'd0, mismatch4}, 16'd0);
    check({tag, "_pass4"}, {15'd0, pass4}, 16'd0);
  endtask

  // Drives one sweep on the selected instance and checks timing and captured values.
  task automatic run_sweep(input logic sel, input logic stuck, input logic repulse, input string tag);
    int hold;
    int busy_cnt;
    int done_at;
    logic [2:0]  abc;
    logic        bsy, dn, ps;
    logic [15:0] res;
    logic [7:0]  mm;
    logic [15:0] exp_r;
    hold = sel ? 1 : 4;
    if (sel) stuck1 = stuck; else stuck4 = stuck;
    exp_q.push_back(exp_result(stuck));
    @(negedge clk);
    if (sel) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    if (sel) start1 = 1'b0; else start4 = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      if (repulse && k == 5) begin if (sel) start1 = 1'b1; else start4 = 1'b1; end
      if (repulse && k == 6) begin if (sel) start1 = 1'b0; else start4 = 1'b0; end
      abc = sel ? {a1, b1, c1} : {a4, b4, c4};
      bsy = sel ? busy1 : busy4;
      dn  = sel ? done1 : done4;
      ps  = sel ? pass1 : pass4;
      res = sel ? result1 : result4;
      mm  = sel ? mismatch1 : mismatch4;
      if (bsy) busy_cnt++;
      if (k < 8 * hold && (k % hold) == 0)
        check({tag, "_abc"}, {13'd0, abc}, 16'(k / hold));
      if (dn && done_at < 0) begin
        done_at = k;
        exp_r = exp_q.pop_front();
        check({tag, "_result"}, res, exp_r);
        check({tag, "_mismatch"}, {8'd0, mm}, {8'd0, exp_mismatch(stuck)});
        check({tag, "_pass"}, {15'd0, ps}, {15'd0, exp_pass(stuck)});
        check({tag, "_abc_done"}, {13'd0, abc}, 16'd0);
      end else if (done_at >= 0 && k == done_at + 1) begin
        check({tag, "_done_low"}, {15'd0, dn}, 16'd0);
        check({tag, "_pass_hold"}, {15'd0, ps}, {15'd0, exp_pass(stuck)});
        check({tag, "_result_hold"}, res, exp_r);
        break;
      end
    end
    if (done_at < 0) begin
      check({tag, "_done_timeout"}, 16'd0, 16'd1);
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_done_at"}, 16'(done_at), 16'(8 * hold));
    end
    check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(8 * hold));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    stuck4 = 1'b0;
    stuck1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("idle");
    end

    run_sweep(1'b0, 1'b0, 1'b0, "h4_good");
    run_sweep(1'b0, 1'b1, 1'b0, "h4_stuckp");
    run_sweep(1'b0, 1'b0, 1'b1, "h4_repulse");

    // Abort a sweep after two captures; asynchronous reset must clear everything at once.
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", {15'd0, busy4}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    run_sweep(1'b0, 1'b0, 1'b0, "h4_after_reset");

    run_sweep(1'b1, 1'b0, 1'b0, "h1_good");
    run_sweep(1'b1, 1'b1, 1'b0, "h1_stuckp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
